ext_pipe: RTL and testbench



---
 rtl/ext_pipe.sv | 188 ++++++++++++++++++
 tb/tb_ext_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_pipe.sv
// ext_pipe: registered immediate extender / load-lane extractor on a
// valid/ready stream. Results are queued in a 2-entry output buffer whose
// head entry drives out_data.
//
// Optional feature macro: EXT_ALIGN_ERR_EN
//   defined   -> adds output 'err', set for LH/LHU with an odd byte offset
//   undefined -> no err port; boff[0] is ignored for halfword loads
module ext_pipe #(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 32,
    parameter int SLL_AMT = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   op,
    input  logic [OUT_W-1:0]             din,
    input  logic [$clog2(OUT_W/8)-1:0]   boff,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             out_data,
    output logic [1:0]                   occ
`ifdef EXT_ALIGN_ERR_EN
    ,
    output logic                         err
`endif
);

    localparam int BOFF_W = $clog2(OUT_W/8);

    typedef enum logic [2:0] {
        OP_SIGN     = 3'b000,
        OP_ZERO     = 3'b001,
        OP_HIGH     = 3'b010,
        OP_SIGN_SLL = 3'b011,
        OP_LB       = 3'b100,
        OP_LBU      = 3'b101,
        OP_LH       = 3'b110,
        OP_LHU      = 3'b111
    } op_e;

    // Arithmetic (combinational)
    op_e               op_s;
    logic [OUT_W-1:0]  sext;
    logic [OUT_W-1:0]  zext;
    logic [BOFF_W-1:0] boff_h;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [OUT_W-1:0]  res;

    // Buffer state: entry 0 is always the head of the FIFO
    logic [OUT_W-1:0]  data_q [2];
    logic [OUT_W-1:0]  data_d [2];
    logic [1:0]        occ_q;
    logic [1:0]        occ_d;
    logic              push;
    logic              pop;

`ifdef EXT_ALIGN_ERR_EN
    logic              res_err;
    logic              err_q [2];
    logic              err_d [2];
`endif

    // Compute the extended result for the current op and operand.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        op_s   = op_e'(op);
        sext   = {OUT_W{din[IN_W-1]}};
        sext[IN_W-1:0] = din[IN_W-1:0];
        zext   = '0;
        zext[IN_W-1:0] = din[IN_W-1:0];
        boff_h = boff;
        boff_h[0] = 1'b0;
        lane_b = 8'(din >> {boff, 3'b000});
        lane_h = 16'(din >> {boff_h, 3'b000});
        res    = sext;
        case (op_s)
            OP_SIGN:     res = sext;
            OP_ZERO:     res = zext;
            OP_HIGH:     res = zext << (OUT_W - IN_W);
            OP_SIGN_SLL: res = sext << SLL_AMT;
            OP_LB: begin
                res = {OUT_W{lane_b[7]}};
                res[7:0] = lane_b;
            end
            OP_LBU: begin
                res = '0;
                res[7:0] = lane_b;
            end
            OP_LH: begin
                res = {OUT_W{lane_h[15]}};
                res[15:0] = lane_h;
            end
            OP_LHU: begin
                res = '0;
                res[15:0] = lane_h;
            end
            default: res = sext;
        endcase
    end

`ifdef EXT_ALIGN_ERR_EN
    // Flag misaligned halfword loads; the result itself uses the aligned lane.
    always_comb begin
        res_err = ((op == OP_LH) || (op == OP_LHU)) && boff[0];
    end
`endif

    // Handshake decode; in_ready ignores out_ready so a full buffer never accepts.
    always_comb begin
        in_ready  = !reset && (occ_q != 2'd2);
        out_valid = (occ_q != 2'd0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        occ       = occ_q;
        out_data  = out_valid ? data_q[0] : '0;
`ifdef EXT_ALIGN_ERR_EN
        err       = out_valid ? err_q[0] : 1'b0;
`endif
    end

    // Next buffer contents: flush wins over push/pop; entry 0 is the head.
    always_comb begin
        occ_d  = occ_q;
        data_d = data_q;
`ifdef EXT_ALIGN_ERR_EN
        err_d  = err_q;
`endif
        if (flush) begin
            occ_d = 2'd0;
        end else begin
            case ({push, pop})
                // Only reachable with occ=1: the new entry becomes the head.
                2'b11: begin
                    data_d[0] = res;
`ifdef EXT_ALIGN_ERR_EN
                    err_d[0]  = res_err;
`endif
                end
                2'b01: begin
                    data_d[0] = data_q[1];
`ifdef EXT_ALIGN_ERR_EN
                    err_d[0]  = err_q[1];
`endif
                    occ_d = occ_q - 2'd1;
                end
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        data_d[0] = res;
`ifdef EXT_ALIGN_ERR_EN
                        err_d[0]  = res_err;
`endif
                    end else begin
                        data_d[1] = res;
`ifdef EXT_ALIGN_ERR_EN
                        err_d[1]  = res_err;
`endif
                    end
                    occ_d = occ_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Occupancy register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            occ_q <= 2'd0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Buffer storage.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; outputs are masked by occ, so stale entries are never visible.
        data_q <= data_d;
`ifdef EXT_ALIGN_ERR_EN
        err_q  <= err_d;
`endif
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe (IN_W=16, OUT_W=32, SLL_AMT=2).
// Expected results are pushed to a scoreboard queue on accept and compared
// when the DUT pops them. Build with +define+EXT_ALIGN_ERR_EN to check err.
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] din;
    logic [1:0]  boff;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occ;
`ifdef EXT_ALIGN_ERR_EN
    logic        err;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Scoreboard entries: {err, data}
    logic [32:0] sb_q[$];
    logic [32:0] exp_v;
    logic        use_exp;
    logic [32:0] hd;

    ext_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .din       (din),
        .boff      (boff),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occ       (occ)
`ifdef EXT_ALIGN_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model of the extender for IN_W=16, OUT_W=32, SLL_AMT=2.
    function automatic logic [32:0] model(input logic [2:0] o, input logic [31:0] d,
                                          input logic [1:0] b);
        logic [31:0] r;
        logic        e;
        int          sh;
        e  = 1'b0;
        sh = (b & 2'b10) * 8;
        case (o)
            3'd0: r = 32'($signed(d[15:0]));
            3'd1: r = {16'h0, d[15:0]};
            3'd2: r = {d[15:0], 16'h0};
            3'd3: r = 32'($signed(d[15:0])) << 2;
            3'd4: r = 32'($signed(d[8*b +: 8]));
            3'd5: r = {24'h0, d[8*b +: 8]};
            3'd6: begin r = 32'($signed(d[sh +: 16])); e = b[0]; end
            default: begin r = {16'h0, d[sh +: 16]}; e = b[0]; end
        endcase
        return {e, r};
    endfunction

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        check("occ", occ, sb_q.size());
        check("out_valid", out_valid, sb_q.size() != 0);
        check("in_ready", in_ready, !reset && (sb_q.size() != 2));
        if (occ == 2'd0) check("empty_data", out_data, 0);
        if (reset || flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    hd = sb_q.pop_front();
                    check("data", out_data, hd[31:0]);
`ifdef EXT_ALIGN_ERR_EN
                    check("err", err, hd[32]);
`endif
                end
            end
            if (in_valid && in_ready)
                sb_q.push_back(use_exp ? exp_v : model(op, din, boff));
        end
    end

    // Present one input with a known expected result and hold it until accepted.
    task automatic send(input logic [2:0] o, input logic [31:0] d, input logic [1:0] b,
                        input logic [32:0] e);
        logic acc;
        op = o; din = d; boff = b; exp_v = e; use_exp = 1'b1; in_valid = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; op = '0; din = '0; boff = '0;
        out_ready = 1'b1; use_exp = 1'b1; exp_v = '0;
        idle(3);
        @(negedge clk);
        check("rst_occ", occ, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_data", out_data, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Immediate modes and loads, one op per cycle, out_ready high.
        send(3'd0, 32'h0000_8001, 2'd0, {1'b0, 32'hFFFF_8001});
        send(3'd1, 32'h0000_8001, 2'd0, {1'b0, 32'h0000_8001});
        send(3'd2, 32'h0000_1234, 2'd0, {1'b0, 32'h1234_0000});
        send(3'd3, 32'h0000_FFFF, 2'd0, {1'b0, 32'hFFFF_FFFC});
        send(3'd4, 32'h80FF_7F01, 2'd3, {1'b0, 32'hFFFF_FF80});
        send(3'd5, 32'h80FF_7F01, 2'd1, {1'b0, 32'h0000_007F});
        send(3'd6, 32'h80FF_7F01, 2'd2, {1'b0, 32'hFFFF_80FF});
        send(3'd7, 32'h80FF_7F01, 2'd2, {1'b0, 32'h0000_80FF});
        send(3'd6, 32'h80FF_7F01, 2'd3, {1'b1, 32'hFFFF_80FF});
        send(3'd7, 32'h80FF_7F01, 2'd1, {1'b1, 32'h0000_7F01});
        idle(3);

        // Backpressure: two entries fill the buffer, the third is held.
        out_ready = 1'b0;
        send(3'd1, 32'd1, 2'd0, {1'b0, 32'd1});
        send(3'd1, 32'd2, 2'd0, {1'b0, 32'd2});
        op = 3'd1; din = 32'd3; exp_v = {1'b0, 32'd3}; in_valid = 1'b1;
        @(negedge clk);
        check("bp_occ_full", occ, 2);
        check("bp_in_ready", in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_head_stable", out_data, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3'd1, 32'd3, 2'd0, {1'b0, 32'd3});
        idle(3);
        @(negedge clk);
        check("bp_in_ready_back", in_ready, 1);
        @(posedge clk); #1;

        // Steady state at occ=1 with simultaneous push and pop.
        out_ready = 1'b0;
        send(3'd1, 32'h100, 2'd0, {1'b0, 32'h100});
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            op = 3'd1; din = 32'h200 + i; exp_v = {1'b0, 32'h200 + 32'(i)}; in_valid = 1'b1;
            @(negedge clk);
            check("steady_occ", occ, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        idle(2);

        // Flush with a full buffer and input presented.
        out_ready = 1'b0;
        send(3'd1, 32'hA, 2'd0, {1'b0, 32'hA});
        send(3'd1, 32'hB, 2'd0, {1'b0, 32'hB});
        flush = 1'b1; in_valid = 1'b1; din = 32'hDEAD; exp_v = {1'b0, 32'hDEAD};
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_occ", occ, 0);
        check("flush_out_valid", out_valid, 0);
        @(posedge clk); #1;
        // Flush at occ=1 while in_ready is high: that input must be dropped.
        send(3'd1, 32'hC, 2'd0, {1'b0, 32'hC});
        flush = 1'b1; in_valid = 1'b1; din = 32'hBEEF; exp_v = {1'b0, 32'hBEEF};
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush1_occ", occ, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3'd1, 32'h55, 2'd0, {1'b0, 32'h55});
        idle(2);

        // Reset with a full buffer and input presented.
        out_ready = 1'b0;
        send(3'd1, 32'h1, 2'd0, {1'b0, 32'h1});
        send(3'd1, 32'h2, 2'd0, {1'b0, 32'h2});
        reset = 1'b1; in_valid = 1'b1; din = 32'h77; exp_v = {1'b0, 32'h77};
        @(posedge clk); #1;
        @(negedge clk);
        check("rst2_occ", occ, 0);
        check("rst2_out_valid", out_valid, 0);
        check("rst2_out_data", out_data, 0);
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst2_in_ready", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3'd1, 32'h99, 2'd0, {1'b0, 32'h99});
        @(negedge clk);
        check("rst2_first_valid", out_valid, 1);
        check("rst2_first_data", out_data, 32'h99);
        @(posedge clk); #1;

        // Random traffic checked against the model.
        use_exp = 1'b0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            op        = 3'($urandom_range(0, 7));
            din       = $urandom;
            boff      = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        idle(5);
        check("drain_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
